fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the multicycle control unit.
- Owns the program counter and the instruction register.
- On each `pc_en` strobe from the control unit, it selects the next PC (sequential, conditional branch, JAL, JALR), fetches that instruction from instruction memory over a valid/ready handshake, and holds it stable.
- Outputs to decode and the control unit: the held instruction, `opcode`, `pc` and `pc_plus4` (the link value).

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and instruction register, fetches over a valid/ready port.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pc_en,
   input  logic [1:0]      branch,
   input  logic            br_taken,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic [31:0]     instr,
   output logic [6:0]      opcode,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            instr_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic            misalign_err,
`endif
   output logic            stall
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   localparam logic [31:0]     NOP   = 32'h0000_0013;
   localparam logic [XLEN-1:0] FOUR  = XLEN'(4);
   localparam logic [XLEN-1:0] CLR0  = {{(XLEN-1){1'b1}}, 1'b0};

   logic [1:0]      state;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     instr_q;
   logic            first;
   logic            valid_q;
   logic [XLEN-1:0] br_sum;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] next_pc;

   assign br_sum   = pc_q + imm;
   assign pc_plus4 = pc_q + FOUR;

   always_comb begin
      target = pc_plus4;
      unique case (branch)
         2'b00: target = pc_plus4;
         2'b01: target = br_taken ? br_sum : pc_plus4;
         2'b10: target = br_sum;
         2'b11: target = (rs1_data + imm) & CLR0;
         default: target = pc_plus4;
      endcase
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic err_q;
   logic misaligned;

   assign misaligned   = |target[1:0];
   assign next_pc      = target;
   assign misalign_err = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (state == S_IDLE && pc_en && !first) begin
         err_q <= misaligned;
      end
   end
`else
   logic misaligned;

   // Without the trap, low bits are simply dropped.
   assign misaligned = 1'b0;
   assign next_pc    = {target[XLEN-1:2], 2'b00};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         first   <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pc_en) begin
                  if (first) begin
                     first <= 1'b0;
                     state <= S_REQ;
                  end else if (!misaligned) begin
                     pc_q  <= next_pc;
                     state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (imem_req_ready) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  instr_q <= imem_rsp_data;
                  valid_q <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign imem_req_valid = (state == S_REQ);
   assign imem_addr      = pc_q;
   assign stall          = (state != S_IDLE);
   assign pc             = pc_q;
   assign instr          = instr_q;
   assign opcode         = instr_q[6:0];
   assign instr_valid    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit: PC selection, handshake timing,
// back-pressure, stray strobes, reset mid-fetch and misaligned targets.
module tb_fetch_unit;

   typedef struct {
      logic [1:0]  br;
      logic        tk;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] data;
      logic [31:0] addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_en;
   logic [1:0]  branch;
   logic        br_taken;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        stall;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_err;
`endif

   int errors = 0;
   int checks = 0;
   vec_t vec [13];

   always #5 clk = ~clk;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .reset(reset),
      .pc_en(pc_en),
      .branch(branch),
      .br_taken(br_taken),
      .imm(imm),
      .rs1_data(rs1_data),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .instr(instr),
      .opcode(opcode),
      .pc(pc),
      .pc_plus4(pc_plus4),
      .instr_valid(instr_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misalign_err(misalign_err),
`endif
      .stall(stall)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full fetch: strobe, one REQ cycle with ready, response one cycle later.
   task automatic fetch(input vec_t v, input string tag);
      branch   = v.br;
      br_taken = v.tk;
      imm      = v.imm;
      rs1_data = v.rs1;
      pc_en    = 1'b1;
      step();
      pc_en = 1'b0;
      chk({tag, " req_addr"}, imem_addr, v.addr);
      chk({tag, " req_valid"}, 32'(imem_req_valid), 32'd1);
      chk({tag, " req_stall"}, 32'(stall), 32'd1);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      chk({tag, " wait_valid"}, 32'(imem_req_valid), 32'd0);
      chk({tag, " wait_stall"}, 32'(stall), 32'd1);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = v.data;
      step();
      imem_rsp_valid = 1'b0;
      chk({tag, " instr"}, instr, v.data);
      chk({tag, " opcode"}, 32'(opcode), 32'(v.data[6:0]));
      chk({tag, " pc"}, pc, v.addr);
      chk({tag, " pc_plus4"}, pc_plus4, v.addr + 32'd4);
      chk({tag, " ivalid"}, 32'(instr_valid), 32'd1);
      chk({tag, " done_stall"}, 32'(stall), 32'd0);
      step();
      chk({tag, " ivalid_drop"}, 32'(instr_valid), 32'd0);
   endtask

   initial begin
      vec_t v;
      vec[0]  = '{2'b00, 1'b0, 32'h0,        32'h0,    32'h00500093, 32'h0};
      vec[1]  = '{2'b10, 1'b0, 32'h100,      32'h0,    32'h00A00113, 32'h100};
      vec[2]  = '{2'b01, 1'b1, 32'hFFFFFFF0, 32'h0,    32'h002081B3, 32'hF0};
      vec[3]  = '{2'b10, 1'b0, 32'h10,       32'h0,    32'h00000063, 32'h100};
      vec[4]  = '{2'b01, 1'b0, 32'hFFFFFFF0, 32'h0,    32'h0000006F, 32'h104};
      vec[5]  = '{2'b10, 1'b1, 32'hFC,       32'h0,    32'h00000067, 32'h200};
      vec[6]  = '{2'b11, 1'b0, 32'h4,        32'h1001, 32'h12345637, 32'h1004};
      vec[7]  = '{2'b10, 1'b0, 32'hFFFFF1FC, 32'h0,    32'h00000013, 32'h200};
      vec[8]  = '{2'b10, 1'b0, 32'h20,       32'h0,    32'hFE000EE3, 32'h220};
      vec[9]  = '{2'b00, 1'b1, 32'h40,       32'h0,    32'h00100073, 32'h224};
      vec[10] = '{2'b10, 1'b0, 32'hFFFFFDD8, 32'h0,    32'hDEADBEEF, 32'hFFFFFFFC};
      vec[11] = '{2'b00, 1'b0, 32'h0,        32'h0,    32'h00000033, 32'h0};
      vec[12] = '{2'b11, 1'b0, 32'hFFFFFFFF, 32'h301,  32'h00008067, 32'h300};

      reset = 1'b1;
      pc_en = 1'b0;
      branch = 2'b00;
      br_taken = 1'b0;
      imm = '0;
      rs1_data = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      step();
      step();
      reset = 1'b0;
      step();

      chk("rst pc", pc, 32'h0);
      chk("rst pc_plus4", pc_plus4, 32'h4);
      chk("rst instr", instr, 32'h13);
      chk("rst opcode", 32'(opcode), 32'h13);
      chk("rst req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst ivalid", 32'(instr_valid), 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("rst misalign", 32'(misalign_err), 32'd0);
`endif

      for (int i = 0; i < 13; i++) begin
         fetch(vec[i], $sformatf("v%0d", i));
      end

      // Back-pressure: ready low for 3 cycles, stray strobe while in REQ.
      branch = 2'b00;
      pc_en  = 1'b1;
      step();
      pc_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp addr%0d", k), imem_addr, 32'h304);
         chk($sformatf("bp stall%0d", k), 32'(stall), 32'd1);
         chk($sformatf("bp valid%0d", k), 32'(imem_req_valid), 32'd1);
         if (k == 1) begin
            pc_en  = 1'b1;
            branch = 2'b10;
            imm    = 32'h40;
         end
         step();
         pc_en = 1'b0;
      end
      chk("bp addr_hold", imem_addr, 32'h304);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      chk("bp wait_stall", 32'(stall), 32'd1);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00C00213;
      step();
      imem_rsp_valid = 1'b0;
      chk("bp instr", instr, 32'h00C00213);
      chk("bp pc", pc, 32'h304);
      chk("bp ivalid", 32'(instr_valid), 32'd1);
      step();
      v = '{2'b00, 1'b0, 32'h0, 32'h0, 32'h00000513, 32'h308};
      fetch(v, "bp_next");

      // Misaligned JAL target from 0x100.
      v = '{2'b10, 1'b0, 32'hFFFFFDF8, 32'h0, 32'h00000593, 32'h100};
      fetch(v, "to100");
`ifdef FETCH_MISALIGN_TRAP_EN
      branch = 2'b10;
      imm    = 32'h6;
      pc_en  = 1'b1;
      step();
      pc_en = 1'b0;
      chk("mis err", 32'(misalign_err), 32'd1);
      chk("mis pc", pc, 32'h100);
      chk("mis req", 32'(imem_req_valid), 32'd0);
      chk("mis stall", 32'(stall), 32'd0);
      step();
      chk("mis err_hold", 32'(misalign_err), 32'd1);
      v = '{2'b00, 1'b0, 32'h0, 32'h0, 32'h00000613, 32'h104};
      fetch(v, "mis_clear");
      chk("mis err_clr", 32'(misalign_err), 32'd0);
`else
      v = '{2'b10, 1'b0, 32'h6, 32'h0, 32'h00000613, 32'h104};
      fetch(v, "mis_force");
`endif

      // Reset while waiting for a response, then a late response.
      branch = 2'b00;
      pc_en  = 1'b1;
      step();
      pc_en = 1'b0;
      chk("rw addr", imem_addr, 32'h108);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      chk("rw in_wait", 32'(stall), 32'd1);
      reset = 1'b1;
      #1;
      chk("rw pc", pc, 32'h0);
      chk("rw stall", 32'(stall), 32'd0);
      chk("rw instr", instr, 32'h13);
      step();
      reset = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hFFFFFFFF;
      step();
      imem_rsp_valid = 1'b0;
      chk("rw late_instr", instr, 32'h13);
      chk("rw late_ivalid", 32'(instr_valid), 32'd0);
      chk("rw late_stall", 32'(stall), 32'd0);
      chk("rw late_req", 32'(imem_req_valid), 32'd0);
      chk("rw late_pc", pc, 32'h0);
      v = '{2'b10, 1'b0, 32'h500, 32'h0, 32'h00100093, 32'h0};
      fetch(v, "rw_first");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
